// File: rtl/alu_issue_if.sv
// Issue-stage bus: instruction intake (producer -> stage) and operation
// issue (stage -> ALU), each with its own valid/ready handshake.
// The stage itself is the slave; the producer/ALU side is the master.
interface alu_issue_if;
    // instruction intake
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    // operation issue
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  issue_rd;
    logic [31:0] alu_out;

    modport slave (
        input  instr_valid, instr, issue_ready, alu_out,
        output instr_ready, issue_valid, alu_ctrl, ra, rb, issue_rd
    );

    modport master (
        output instr_valid, instr, issue_ready, alu_out,
        input  instr_ready, issue_valid, alu_ctrl, ra, rb, issue_rd
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: RV32I OP/OP-IMM decode and issue stage with a 32x32 register
// file, one-entry issue register and writeback of the ALU result at fire.
// Optional feature macro: ALU_ISSUE_BYPASS_EN. When defined, a dependent
// instruction accepted in the same cycle as the producing issue fires takes
// alu_out directly; when undefined, such an instruction is held off for one
// cycle until the writeback has landed in the register file.
module alu_issue (
    input  logic        clk,
    input  logic        reset,
    alu_issue_if.slave  bus,
    output logic        illegal,
    output logic [31:0] retire_cnt,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rd;
    } issue_t;

    logic [31:0] regs [0:31];
    issue_t      issue_q;
    logic        issue_valid_q;

    // instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;

    assign opcode = bus.instr[6:0];
    assign rd     = bus.instr[11:7];
    assign funct3 = bus.instr[14:12];
    assign rs1    = bus.instr[19:15];
    assign rs2    = bus.instr[24:20];
    assign funct7 = bus.instr[31:25];
    assign imm    = {{20{bus.instr[31]}}, bus.instr[31:20]};

    // decode results
    logic       legal;
    logic       uses_rs2;
    logic [3:0] dec_ctrl;

    // Decode opcode/funct fields into ALU select and legality.
    always_comb begin
        legal    = 1'b0;
        uses_rs2 = 1'b0;
        dec_ctrl = 4'b0000;
        case (opcode)
            OPC_OP: begin
                uses_rs2 = 1'b1;
                dec_ctrl = {bus.instr[30], funct3};
                legal    = (funct7 == F7_ZERO) ||
                           ((funct7 == F7_ALT) &&
                            ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                dec_ctrl = {(funct3 == 3'b101) ? bus.instr[30] : 1'b0, funct3};
                case (funct3)
                    3'b001:  legal = (funct7 == F7_ZERO);
                    3'b101:  legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // handshakes
    logic accept;
    logic fire;
    logic stall;

    assign fire   = issue_valid_q & bus.issue_ready;
    assign accept = bus.instr_valid & bus.instr_ready;

    // register-file reads; x0 is hard zero
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] op_a;
    logic [31:0] op_b;

    assign rs1_data = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_data = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

`ifdef ALU_ISSUE_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    // The writeback of the firing issue lands at this same edge, so a
    // dependent source has to take the ALU result directly.
    assign fwd_a = fire && (issue_q.rd != 5'd0) && (rs1 == issue_q.rd);
    assign fwd_b = fire && (issue_q.rd != 5'd0) && uses_rs2 && (rs2 == issue_q.rd);
    assign op_a  = fwd_a ? bus.alu_out : rs1_data;
    assign op_b  = fwd_b ? bus.alu_out : rs2_data;
    assign stall = 1'b0;
`else
    // Without forwarding, hold a dependent instruction until the pending
    // issue has fired and its result sits in the register file.
    assign op_a  = rs1_data;
    assign op_b  = rs2_data;
    assign stall = issue_valid_q && legal && (issue_q.rd != 5'd0) &&
                   ((rs1 == issue_q.rd) || (uses_rs2 && (rs2 == issue_q.rd)));
`endif

    assign bus.instr_ready = (!issue_valid_q || bus.issue_ready) && !stall;

    // Issue register: load on legal accept, drain on fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_valid_q <= 1'b0;
            issue_q       <= '0;
        end else if (accept && legal) begin
            issue_valid_q <= 1'b1;
            issue_q.ctrl  <= dec_ctrl;
            issue_q.ra    <= op_a;
            issue_q.rb    <= uses_rs2 ? op_b : imm;
            issue_q.rd    <= rd;
        end else if (fire) begin
            issue_valid_q <= 1'b0;
        end
    end

    // Illegal pulse for the cycle after an undecodable instruction is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal <= 1'b0;
        end else begin
            illegal <= accept && !legal;
        end
    end

    // Writeback of the ALU result at fire; x0 is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (fire && (issue_q.rd != 5'd0)) begin
            regs[issue_q.rd] <= bus.alu_out;
        end
    end

    // Retired-writeback counter, including writebacks to x0; wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt <= 32'd0;
        end else if (fire) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.alu_ctrl    = issue_q.ctrl;
    assign bus.ra          = issue_q.ra;
    assign bus.rb          = issue_q.rb;
    assign bus.issue_rd    = issue_q.rd;

    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue. A small behavioural ALU answers each issue;
// every expected value below is worked out by hand from the RV32I semantics.
module tb_alu_issue;

    logic        clk;
    logic        reset;
    logic        illegal;
    logic [31:0] retire_cnt;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_if bus ();

    alu_issue dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .illegal    (illegal),
        .retire_cnt (retire_cnt),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU standing in for the consumer.
    always_comb begin
        case (bus.alu_ctrl)
            4'b0000: bus.alu_out = bus.ra + bus.rb;
            4'b1000: bus.alu_out = bus.ra - bus.rb;
            4'b0001: bus.alu_out = bus.ra << bus.rb[4:0];
            4'b0010: bus.alu_out = {31'd0, $signed(bus.ra) < $signed(bus.rb)};
            4'b0011: bus.alu_out = {31'd0, bus.ra < bus.rb};
            4'b0100: bus.alu_out = bus.ra ^ bus.rb;
            4'b0101: bus.alu_out = bus.ra >> bus.rb[4:0];
            4'b1101: bus.alu_out = $unsigned($signed(bus.ra) >>> bus.rb[4:0]);
            4'b0110: bus.alu_out = bus.ra | bus.rb;
            4'b0111: bus.alu_out = bus.ra & bus.rb;
            default: bus.alu_out = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present an instruction and return once it has been accepted (#1 after
    // the accepting edge); waits reports the cycles spent stalled.
    task automatic send(input logic [31:0] word, output int waits);
        bus.instr_valid = 1'b1;
        bus.instr       = word;
        waits = 0;
        forever begin
            @(negedge clk);
            if (bus.instr_ready) break;
            waits++;
            if (waits > 20) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_issue_valid"}, {31'd0, bus.issue_valid}, 32'd0);
        chk({tag, "_illegal"},     {31'd0, illegal}, 32'd0);
        chk({tag, "_alu_ctrl"},    {28'd0, bus.alu_ctrl}, 32'd0);
        chk({tag, "_ra"},          bus.ra, 32'd0);
        chk({tag, "_rb"},          bus.rb, 32'd0);
        chk({tag, "_issue_rd"},    {27'd0, bus.issue_rd}, 32'd0);
        chk({tag, "_retire_cnt"},  retire_cnt, 32'd0);
        chk({tag, "_instr_ready"}, {31'd0, bus.instr_ready}, 32'd1);
    endtask

    int w0, w1, w2;
    int exp_bubble;

    initial begin
`ifdef ALU_ISSUE_BYPASS_EN
        exp_bubble = 0;
`else
        exp_bubble = 1;
`endif
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.issue_ready = 1'b0;
        dbg_addr        = 5'd0;
        tick();
        tick();
        chk_zero_outputs("reset");
        reset = 1'b0;

        // ADDI x1,x0,5
        bus.issue_ready = 1'b1;
        send(32'h00500093, w0);
        bus.instr_valid = 1'b0;
        chk("addi_valid", {31'd0, bus.issue_valid}, 32'd1);
        chk("addi_ctrl",  {28'd0, bus.alu_ctrl}, 32'h0);
        chk("addi_ra",    bus.ra, 32'd0);
        chk("addi_rb",    bus.rb, 32'd5);
        chk("addi_rd",    {27'd0, bus.issue_rd}, 32'd1);
        tick();
        chk("addi_drained", {31'd0, bus.issue_valid}, 32'd0);
        rd_reg("x1_eq5", 5'd1, 32'd5);
        chk("retire_1", retire_cnt, 32'd1);

        // Dependent chain: ADDI x1,x0,5 ; ADDI x2,x1,-3 ; SUB x3,x2,x1
        send(32'h00500093, w0);
        send(32'hFFD08113, w1);
        send(32'h401101B3, w2);
        bus.instr_valid = 1'b0;
        chk("sub_ctrl", {28'd0, bus.alu_ctrl}, 32'h8);
        tick();
        chk("bubble_addi", w1, exp_bubble);
        chk("bubble_sub",  w2, exp_bubble);
        rd_reg("x2_eq2", 5'd2, 32'd2);
        rd_reg("x3_eq_m3", 5'd3, 32'hFFFFFFFD);
        chk("retire_4", retire_cnt, 32'd4);

        // x6 = 1 ; x4 = x6 << 31
        send(32'h00100313, w0);
        send(32'h01F31213, w0);
        bus.instr_valid = 1'b0;
        tick();
        rd_reg("x4_msb", 5'd4, 32'h80000000);
        chk("retire_6", retire_cnt, 32'd6);

        // SRAI x5,x4,4
        send(32'h40425293, w0);
        bus.instr_valid = 1'b0;
        chk("srai_ctrl", {28'd0, bus.alu_ctrl}, 32'hD);
        chk("srai_ra",   bus.ra, 32'h80000000);
        chk("srai_rb",   bus.rb, 32'h00000404);
        tick();
        rd_reg("x5_sra", 5'd5, 32'hF8000000);
        chk("retire_7", retire_cnt, 32'd7);

        // ADDI x7,x0,9 held by issue_ready=0 for three cycles
        bus.issue_ready = 1'b0;
        send(32'h00900393, w0);
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_ready", {31'd0, bus.instr_ready}, 32'd0);
            chk("hold_valid", {31'd0, bus.issue_valid}, 32'd1);
            chk("hold_rb",    bus.rb, 32'd9);
            chk("hold_rd",    {27'd0, bus.issue_rd}, 32'd7);
            chk("hold_retire", retire_cnt, 32'd7);
            rd_reg("hold_x7", 5'd7, 32'd0);
        end
        bus.issue_ready = 1'b1;
        tick();
        rd_reg("x7_eq9", 5'd7, 32'd9);
        chk("retire_8", retire_cnt, 32'd8);

        // Illegal encodings: ECALL, SLLI with bit30, SLL with funct7=0100000
        send(32'h00000073, w0);
        bus.instr_valid = 1'b0;
        chk("ecall_pulse", {31'd0, illegal}, 32'd1);
        chk("ecall_noissue", {31'd0, bus.issue_valid}, 32'd0);
        tick();
        chk("ecall_pulse_end", {31'd0, illegal}, 32'd0);
        send(32'h40009093, w0);
        bus.instr_valid = 1'b0;
        chk("slli30_pulse", {31'd0, illegal}, 32'd1);
        chk("slli30_noissue", {31'd0, bus.issue_valid}, 32'd0);
        tick();
        chk("slli30_pulse_end", {31'd0, illegal}, 32'd0);
        send(32'h40001033, w0);
        bus.instr_valid = 1'b0;
        chk("sll_f7_pulse", {31'd0, illegal}, 32'd1);
        tick();
        chk("illegal_retire", retire_cnt, 32'd8);
        rd_reg("x1_untouched", 5'd1, 32'd5);

        // ADDI x8,x0,3 fires in the same cycle ECALL is accepted
        send(32'h00300413, w0);
        send(32'h00000073, w1);
        bus.instr_valid = 1'b0;
        chk("fire_illegal_valid", {31'd0, bus.issue_valid}, 32'd0);
        chk("fire_illegal_pulse", {31'd0, illegal}, 32'd1);
        chk("fire_illegal_nostall", w1, 32'd0);
        rd_reg("x8_eq3", 5'd8, 32'd3);
        chk("retire_9", retire_cnt, 32'd9);

        // ADDI x0,x0,7 retires but never writes x0
        send(32'h00700013, w0);
        bus.instr_valid = 1'b0;
        tick();
        rd_reg("x0_zero", 5'd0, 32'd0);
        chk("retire_10", retire_cnt, 32'd10);

        // ADDI x9,x0,1 pending when reset hits
        bus.issue_ready = 1'b0;
        send(32'h00100493, w0);
        bus.instr_valid = 1'b0;
        chk("pending_valid", {31'd0, bus.issue_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        bus.issue_ready = 1'b1;
        chk_zero_outputs("midreset");
        tick();
        reset = 1'b0;
        tick();
        chk_zero_outputs("postreset");
        for (int r = 1; r < 32; r++) begin
            rd_reg("postreset_reg", r[4:0], 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage that feeds the 32-bit ALU from the producer side. It accepts RV32I OP/OP-IMM instructions over a valid/ready handshake and decodes them into `alu_ctrl`. It reads operands from an internal 32x32 register file, holds the result in a one-entry issue register, and writes the ALU result back to `rd` when the issue handshake completes.

## Interface
- No parameters; all widths are fixed by RV32I.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `instr_valid` input 1: `instr` holds an instruction to accept.
- `instr` input 32: RV32I instruction word.
- `instr_ready` output 1: stage can accept this cycle.
- `issue_valid` output 1: `alu_ctrl`/`ra`/`rb`/`issue_rd` are valid.
- `issue_ready` input 1: ALU consumer takes the issue this cycle.
- `alu_ctrl` output 4: ALU operation select.
- `ra` output 32: operand 1, always rs1 data.
- `rb` output 32: operand 2, either rs2 data or sign-extended imm[11:0].
- `issue_rd` output 5: destination register of the issued operation.
- `alu_out` input 32: combinational ALU result for the current issue, sampled at fire.
- `illegal` output 1: one-cycle pulse, accepted instruction was not decodable.
- `retire_cnt` output 32: count of completed writebacks, including rd=x0.
- `dbg_addr` input 5: debug read address.
- `dbg_data` output 32: combinational register-file read; x0 reads 0.

## Operation
- Accept happens when `instr_valid & instr_ready`. Fire happens when `issue_valid & issue_ready`.
- `instr_ready = !issue_valid | issue_ready`, subject to the stall rule in Configuration.
- Opcode 0110011 (OP):
  - `alu_ctrl = {instr[30], funct3}`; `rb = x[rs2]`.
  - funct7 must be 0000000, or 0100000 only with funct3 000 or 101. Any other funct7 is illegal.
- Opcode 0010011 (OP-IMM):
  - `rb = {{20{instr[31]}}, instr[31:20]}`.
  - `alu_ctrl = {funct3==101 ? instr[30] : 0, funct3}`.
  - SLLI requires instr[31:25]=0000000. SRLI/SRAI require instr[31:25] of 0000000 or 0100000. Anything else is illegal.
- Encodings: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Any other opcode is illegal.
- Illegal instruction handling:
  - It is accepted normally and never loads the issue register.
  - `illegal` pulses high for the cycle after accept.
  - If the prior issue fires in the same cycle, `issue_valid` drops.
- At fire:
  - `x[issue_rd] <= alu_out` unless `issue_rd==0`.
  - `retire_cnt` increments and wraps modulo 2^32.
- x0 always reads 0 and is never written.
- Simultaneous fire and accept: the issue register reloads with the new instruction and `issue_valid` stays high.

## Timing
- Reset values:
  - `issue_valid`, `illegal`, `alu_ctrl`, `ra`, `rb`, `issue_rd`, `retire_cnt` are all 0.
  - All registers x0..x31 are 0.
  - `instr_ready` is 1.
- Latency: an instruction accepted at edge N has `issue_valid` high after edge N. Outputs stay stable until fire.
- Writeback takes effect at the fire edge. A read in the following cycle, via `dbg_data` or decode, sees the new value.
- Reset asserted mid-operation drops any pending issue and performs no writeback for it.
- `dbg_data` is combinational from the register file and does not see bypass values.

## Configuration
- `ALU_ISSUE_BYPASS_EN` defined:
  - When accept coincides with fire and rs1/rs2 (rs2 only for OP) equals `issue_rd`, with `issue_rd != 0`, the matching operand takes `alu_out`.
  - Back-to-back dependent instructions have no bubble.
- `ALU_ISSUE_BYPASS_EN` undefined:
  - `instr_ready` is forced to 0 while `issue_valid` is high and the pending `instr` sources `issue_rd` (nonzero, rs2 only for OP).
  - A dependent instruction therefore incurs exactly one bubble cycle.
  - Illegal or non-dependent instructions are not stalled.

## Test plan
- Reset, then issue 0x00500093 (ADDI x1,x0,5) with `issue_ready=1` -> `alu_ctrl=0000`, `ra=0`, `rb=5`, `issue_rd=1`; then `dbg_addr=1` reads 5 and `retire_cnt=1`.
- Back-to-back 0x00500093, 0xFFD08113 (ADDI x2,x1,-3), 0x401101B3 (SUB x3,x2,x1):
  - x2=2 and x3=0xFFFFFFFD.
  - With the macro the three fire on consecutive cycles; without it, one bubble appears before each dependent instruction.
- Hold `issue_ready=0` for 3 cycles with `issue_valid` high -> `instr_ready=0`, outputs unchanged, no writeback.
- Issue SRAI x5,x4,4 (0x40425293) with x4=0x80000000 -> `alu_ctrl=1101`; x5=0xF8000000.
- Issue 0x00000073 (ECALL) and SLLI with instr[30]=1 -> each gives a one-cycle `illegal` pulse, no issue, `retire_cnt` unchanged.
- Issue ADDI x0,x0,7, then assert `reset` with an issue pending -> x0 stays 0; after reset all outputs are 0 and x1..x31 read 0.
